// File: rtl/parking_access_ctrl_param.sv
// ---------------------------------------------------------------------------
// parking_access_ctrl_param
//
// Entry/exit controller for a single parking lane gate. A car arriving at the
// gate is asked for a PIN. A correct PIN opens the gate until the car passes
// or a timeout expires, and then a one-cycle close command is issued.
// Consecutive wrong PINs are counted and raise a sticky alarm at the limit.
// A car detected on the arrival and pass sensors at the same time
// (tailgating or a blocked gate) latches a block alarm. Only a correct PIN
// clears that alarm. A lot occupancy counter refuses new arrivals while the
// lot is full.
//
// Parameters
//   PW_W          PIN width in bits
//   PASSWORD      correct PIN
//   MAX_ATTEMPTS  consecutive wrong PINs that raise alarm_pin (>=1)
//   CAPACITY      lot capacity in cars (>=1)
//   GATE_TIMEOUT  cycles the gate stays open without a pass (>=1)
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   sensor_arrive  car present at the entry
//   sensor_pass    car has passed the gate
//   sensor_exit    one-cycle pulse per car leaving the lot
//   try_psswrd     strobe: evaluate psswrd_atmpt this cycle
//   psswrd_atmpt   entered PIN
//   alarm_pin      sticky wrong-PIN alarm
//   alarm_block    tailgating/block alarm
//   open_gate      gate open command (high for the whole open phase)
//   close_gate     one-cycle gate close command
//   full           occupancy == CAPACITY
//   occupancy      cars currently in the lot
//   attempts       consecutive wrong PINs, saturating at MAX_ATTEMPTS
//
// All outputs are registered and are derived from the next-state values, so
// they change on the same edge as the state.
// ---------------------------------------------------------------------------
module parking_access_ctrl_param #(
  parameter int              PW_W         = 8,
  parameter logic [PW_W-1:0] PASSWORD     = PW_W'(87),
  parameter int              MAX_ATTEMPTS = 3,
  parameter int              CAPACITY     = 16,
  parameter int              GATE_TIMEOUT = 1000,
  localparam int             AW           = $clog2(MAX_ATTEMPTS + 1),
  localparam int             OW           = $clog2(CAPACITY + 1),
  localparam int             TW           = $clog2(GATE_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sensor_arrive,
  input  logic            sensor_pass,
  input  logic            sensor_exit,
  input  logic            try_psswrd,
  input  logic [PW_W-1:0] psswrd_atmpt,
  output logic            alarm_pin,
  output logic            alarm_block,
  output logic            open_gate,
  output logic            close_gate,
  output logic            full,
  output logic [OW-1:0]   occupancy,
  output logic [AW-1:0]   attempts
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PIN   = 3'd1,
    ST_OPEN  = 3'd2,
    ST_CLOSE = 3'd3,
    ST_BLOCK = 3'd4
  } state_t;

  localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_ATTEMPTS);
  localparam logic [OW-1:0] OCC_MAX  = OW'(CAPACITY);
  localparam logic [TW-1:0] TMR_LAST = TW'(GATE_TIMEOUT - 1);

  // State and registered outputs
  state_t          state_r;
  logic [AW-1:0]   attempts_r;
  logic            alarm_pin_r;
  logic            alarm_block_r;
  logic            open_gate_r;
  logic            close_gate_r;
  logic [OW-1:0]   occupancy_r;
  logic            full_r;
  logic [TW-1:0]   timer_r;

  // Next-state values
  state_t          state_s;
  logic [AW-1:0]   attempts_s;
  logic            alarm_pin_s;
  logic [OW-1:0]   occupancy_s;
  logic [TW-1:0]   timer_s;

  // Decoded conditions
  logic            correct_s;
  logic            block_s;
  logic            car_in_s;
  logic            car_out_s;
  logic [AW-1:0]   att_inc_s;

  assign correct_s = try_psswrd && (psswrd_atmpt == PASSWORD);
  assign block_s   = sensor_arrive && sensor_pass;
  // The counter holds at the limit instead of wrapping.
  assign att_inc_s = (attempts_r == ATT_MAX) ? attempts_r : (attempts_r + AW'(1'b1));
  // An exit with an empty lot is a spurious pulse and is dropped.
  assign car_out_s = sensor_exit && (occupancy_r != {OW{1'b0}});

  // Next-state, attempt counter and PIN alarm decode
  always_comb begin
    state_s     = state_r;
    attempts_s  = attempts_r;
    alarm_pin_s = alarm_pin_r;
    car_in_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (block_s) begin
          state_s = ST_BLOCK;
        end else if (sensor_arrive && !full_r) begin
          state_s = ST_PIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PIN: begin
        if (block_s) begin
          state_s = ST_BLOCK;
        end else if (correct_s) begin
          state_s     = ST_OPEN;
          attempts_s  = {AW{1'b0}};
          alarm_pin_s = 1'b0;
        end else begin
          // A wrong try is counted even if the car leaves on the same cycle.
          if (try_psswrd) begin
            attempts_s  = att_inc_s;
            alarm_pin_s = alarm_pin_r || (att_inc_s == ATT_MAX);
          end else begin
            attempts_s  = attempts_r;
            alarm_pin_s = alarm_pin_r;
          end
          if (!sensor_arrive) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_PIN;
          end
        end
      end
      ST_OPEN: begin
        if (block_s) begin
          state_s = ST_BLOCK;
        end else if (sensor_pass) begin
          // sensor_arrive is known low here, so this is a clean pass.
          state_s  = ST_CLOSE;
          car_in_s = 1'b1;
        end else if (timer_r == TMR_LAST) begin
          state_s = ST_CLOSE;
        end else begin
          state_s = ST_OPEN;
        end
      end
      ST_CLOSE: begin
        state_s = ST_IDLE;
      end
      ST_BLOCK: begin
        // Leaving BLOCK does not touch the attempt counter or PIN alarm.
        if (correct_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BLOCK;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Occupancy and gate-timer next values
  always_comb begin
    occupancy_s = occupancy_r;
    timer_s     = {TW{1'b0}};
    // A simultaneous entry and exit request cancel each other out.
    if (car_in_s && sensor_exit) begin
      occupancy_s = occupancy_r;
    end else if (car_in_s) begin
      occupancy_s = occupancy_r + OW'(1'b1);
    end else if (car_out_s) begin
      occupancy_s = occupancy_r - OW'(1'b1);
    end else begin
      occupancy_s = occupancy_r;
    end
    // The timer runs only while OPEN persists, so it is 0 on every entry.
    if ((state_r == ST_OPEN) && (state_s == ST_OPEN)) begin
      timer_s = timer_r + TW'(1'b1);
    end else begin
      timer_s = {TW{1'b0}};
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      attempts_r    <= {AW{1'b0}};
      alarm_pin_r   <= 1'b0;
      alarm_block_r <= 1'b0;
      open_gate_r   <= 1'b0;
      close_gate_r  <= 1'b0;
      occupancy_r   <= {OW{1'b0}};
      full_r        <= 1'b0;
      timer_r       <= {TW{1'b0}};
    end else begin
      state_r       <= state_s;
      attempts_r    <= attempts_s;
      alarm_pin_r   <= alarm_pin_s;
      alarm_block_r <= (state_s == ST_BLOCK);
      open_gate_r   <= (state_s == ST_OPEN);
      close_gate_r  <= (state_s == ST_CLOSE);
      occupancy_r   <= occupancy_s;
      full_r        <= (occupancy_s == OCC_MAX);
      timer_r       <= timer_s;
    end
  end

  assign alarm_pin   = alarm_pin_r;
  assign alarm_block = alarm_block_r;
  assign open_gate   = open_gate_r;
  assign close_gate  = close_gate_r;
  assign full        = full_r;
  assign occupancy   = occupancy_r;
  assign attempts    = attempts_r;

endmodule

// File: doc/parking_access_ctrl_param.md
Name: parking_access_ctrl_param

Overview:
Parametrised entry and exit controller for one parking lane gate. It sequences arrival, PIN check, gate open, car pass and gate close. It adds a configurable attempt limit with a sticky PIN alarm, a gate-open timeout, and a lot occupancy counter with a full flag that refuses entry when capacity is reached. It sits between the lane sensors and keypad and the gate actuator driver, and replaces the fixed 8-bit, 3-attempt controller.

Parameters:
PW_W, 8, password and attempt width in bits
PASSWORD, 87, correct PIN (PW_W bits)
MAX_ATTEMPTS, 3, consecutive wrong PINs that raise alarm_pin (>=1)
CAPACITY, 16, lot capacity in cars (>=1)
GATE_TIMEOUT, 1000, cycles the gate stays open without sensor_pass before auto-close (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
sensor_arrive  in  1  car present at entry
sensor_pass  in  1  car has passed the gate
sensor_exit  in  1  one-cycle pulse per car leaving the lot
try_psswrd  in  1  one-cycle strobe: evaluate psswrd_atmpt this cycle
psswrd_atmpt  in  PW_W  entered PIN
alarm_pin  out  1  wrong-PIN alarm, sticky
alarm_block  out  1  tailgating/block alarm
open_gate  out  1  gate open command
close_gate  out  1  one-cycle gate close command
full  out  1  occupancy == CAPACITY
occupancy  out  $clog2(CAPACITY+1)  cars currently in the lot
attempts  out  $clog2(MAX_ATTEMPTS+1)  consecutive wrong PINs, saturating

Behaviour:
- All outputs are registered. They are Moore-style, or updated on the same clock edge as the state.
- On rst: state=IDLE, attempts=0, occupancy=0. All alarms, open_gate and close_gate are 0; full=0.
- "Correct" means try_psswrd=1 and psswrd_atmpt==PASSWORD. psswrd_atmpt is ignored when try_psswrd=0.
- Block condition: sensor_arrive & sensor_pass in IDLE, PIN or OPEN. It has the highest priority and moves the state to BLOCK.
- IDLE:
  - block condition -> BLOCK.
  - else sensor_arrive & !full -> PIN.
  - else stay. An arrival while full is ignored.
- PIN:
  - correct -> OPEN; attempts=0; alarm_pin=0.
  - try_psswrd with a wrong PIN -> attempts+1, saturating at MAX_ATTEMPTS. alarm_pin is set on the edge where attempts reaches MAX_ATTEMPTS. Stay in PIN.
  - !sensor_arrive (car left) -> IDLE. attempts and alarm_pin are retained.
  - Only a correct PIN or rst clears attempts and alarm_pin.
- OPEN:
  - open_gate=1. A timer loads 0 on entry and increments each cycle.
  - sensor_pass alone -> CLOSE; occupancy+1.
  - timer reaches GATE_TIMEOUT-1 with no pass -> CLOSE; no increment.
- CLOSE:
  - open_gate=0 and close_gate=1 for exactly one cycle, then -> IDLE unconditionally.
- BLOCK:
  - alarm_block=1 and open_gate=0.
  - Only a correct PIN exits: -> IDLE, alarm_block=0.
  - Correct PIN in BLOCK does not modify attempts. Wrong tries in BLOCK are not counted.
- Occupancy:
  - sensor_exit decrements, saturating at 0.
  - An increment at occupancy==CAPACITY cannot occur, because entry is gated by full.
  - Increment and decrement on the same cycle leave occupancy unchanged.
  - sensor_exit is honoured in every state, including BLOCK.
  - full is registered and follows occupancy on the same edge.
- Reset mid-operation: rst in any state returns every register to its reset value on the next edge. open_gate drops immediately with no close pulse.

Test Plan:
1. Defaults. sensor_arrive=1, then try with 87 -> PIN then OPEN; open_gate=1, attempts=0. Then sensor_pass=1 with arrive=0 -> close_gate high for 1 cycle, occupancy=1, state back to IDLE.
2. In PIN, try 12, 13, 14 -> attempts=1,2,3; alarm_pin=1 after the third. A 4th wrong try keeps attempts=3. Try 87 -> alarm_pin=0, attempts=0, open_gate=1.
3. sensor_arrive=1 and sensor_pass=1 together in IDLE -> alarm_block=1. Try 5 -> alarm stays. Try 87 -> alarm_block=0, IDLE, occupancy unchanged.
4. GATE_TIMEOUT=8, gate opened, no pass -> open_gate high exactly 8 cycles, then close_gate pulse, occupancy unchanged.
5. CAPACITY=2, admit 2 cars -> full=1. Arrival is ignored (stays IDLE). sensor_exit pulse -> occupancy=1, full=0. Pulse sensor_exit at occupancy 0 -> stays 0.
6. Assert rst while in OPEN -> next edge open_gate=0, close_gate=0, state IDLE, occupancy=0. Also check the simultaneous case: pass and exit on the same cycle leave occupancy unchanged.
